riscv_dmem: RTL and testbench
=============================

# riscv_dmem

Data-memory responder for `riscv_core`: the slave end of the core's dmem request interface (address, read/write enable, 4-bit byte enable). Word-organised RAM with byte-lane writes, registered read data, a one-cycle valid strobe, and an error strobe for illegal requests. Sits beside the instruction memory in the SoC top and in core-level simulation benches, replacing hand-driven `dmem_data_in` stimulus.

## Interface

- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `DEPTH_WORDS*4`.
- `WAIT_CYCLES`, 2: wait states per access when `RISCV_DMEM_WAIT_EN` is defined; 0..15.
- `clk_in`  input  1: clock; all logic on rising edge.
- `rst_in`  input  1: asynchronous, active-low reset.
- `dmem_addr_in`  input  32: byte address from core; bits [1:0] ignored.
- `dmem_data_in`  input  32: store data, already lane-aligned by core.
- `dmem_read_enable_in`  input  1: load request.
- `dmem_write_enable_in`  input  1: store request.
- `dmem_byte_enable_in`  input  4: store lane mask; bit i writes byte i.
- `dmem_data_out`  output  32: full load word; core performs extraction/sign-extension.
- `dmem_valid_out`  output  1: one-cycle response strobe (loads and stores).
- `dmem_ready_out`  output  1: request may be accepted this cycle.
- `dmem_error_out`  output  1: one-cycle strobe, coincident with valid, on illegal request.

## Operation

- Accept: rising edge with `dmem_ready_out`=1 and (read | write) enable high. Request inputs are ignored while ready=0.
- Word index = (`dmem_addr_in` − `BASE_ADDR`) >> 2. Out of range (index ≥ `DEPTH_WORDS` or address < `BASE_ADDR`): no write, `dmem_data_out`=0, error=1.
- Read and write both high: illegal; no write, data 0, error=1.
- Store: enabled lanes written at the accept edge; disabled lanes unchanged; byte enable 4'b0000 is a legal no-op acknowledged with valid, error=0. Store responses drive `dmem_data_out`=0.
- Load: word sampled at the accept edge into the output register; a load accepted the edge after a store to the same word returns the updated data (no stale read).
- `dmem_data_out` holds its value until the next response; only valid/error are strobes.
- FSM (wait-state build): IDLE (ready=1) → accept → WAIT (ready=0, counter loaded with `WAIT_CYCLES`, decremented per edge) → counter 0 → RESP (valid=1, ready=1) → IDLE, or directly back to WAIT on a new accept in RESP.

## Timing

- Reset (rst_in=0, asynchronous): data_out=0, valid=0, error=0, ready=0, FSM=IDLE, counter=0. Ready rises in the first cycle after release. RAM contents not reset.
- Reset mid-transaction: response dropped, no valid; a store already committed at its accept edge remains in RAM.
- Base latency: accept at edge N → valid/error/data in the cycle after edge N+W, W = `WAIT_CYCLES` (or 0 without macro).
- W=0: ready constant 1 outside reset; back-to-back accepts every cycle, one valid per accept.
- W>0: ready low from edge N to edge N+W; high again in the valid cycle, so the next accept may coincide with the edge ending valid.

## Configuration

- `RISCV_DMEM_WAIT_EN` defined: FSM and wait counter built; latency W+1 cycles, ready throttles as above.
- Undefined: no FSM/counter; `WAIT_CYCLES` ignored; fixed 1-cycle latency, ready=1 whenever out of reset.

## Structure

- Shared package `riscv_pkg`: `dmem_state_t` (IDLE, WAIT, RESP), `WORD_BYTES`=4, byte-lane width constant 8.
- Sub-module `dmem_bram`: `DEPTH_WORDS`×32 array, one synchronous read port, one byte-masked write port, read-first on same-edge collision (top prevents collisions by accept serialisation).
- Top holds address decode, error check, output registers, FSM.

## Test plan

- Reset: hold rst_in=0 with requests active → data_out=0, valid=0, error=0, ready=0; no RAM write occurs.
- Store/load: sw 32'hDEADBEEF (be=4'hF) to 0x40, then lw 0x40 → valid pulse each, load returns 32'hDEADBEEF one cycle (W=0) after accept.
- Byte lanes: over 32'hDEADBEEF store 32'h0000_7700 with be=4'b0010 → lw 0x40 returns 32'hDEAD77EF; be=4'h0 store → valid, data unchanged.
- Errors: load at `BASE_ADDR`+4*`DEPTH_WORDS` → valid=1, error=1, data 0; read+write high to 0x40 → error=1, word unchanged.
- Wait states (macro, W=2): accept at edge N → ready low two cycles, valid in cycle after N+2; requests presented while ready=0 ignored.
- Reset mid-op (macro, W=2): store then assert rst_in in WAIT → no valid; after release, lw returns stored word.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the riscv_dmem data-memory responder and its RAM.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_W     = 8;

endpackage

// File: rtl/dmem_bram.sv
// Word-organised RAM: one synchronous read port, one byte-masked write port, read-first.
module dmem_bram
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    be_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Contents are deliberately not reset so this maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be_i[i]) begin
          mem_q[waddr_i][i*BYTE_W +: BYTE_W] <= wdata_i[i*BYTE_W +: BYTE_W];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/riscv_dmem.sv
// Data-memory responder for riscv_core. Define RISCV_DMEM_WAIT_EN to build the
// wait-state FSM; otherwise every accepted request answers one cycle later.
module riscv_dmem
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] dmem_addr_in,
  input  logic [31:0] dmem_data_in,
  input  logic        dmem_read_enable_in,
  input  logic        dmem_write_enable_in,
  input  logic [3:0]  dmem_byte_enable_in,
  output logic [31:0] dmem_data_out,
  output logic        dmem_valid_out,
  output logic        dmem_ready_out,
  output logic        dmem_error_out
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0]   offset;
  logic          in_range;
  logic          accept;
  logic          err_now;
  logic          load_ok_now;
  logic          store_ok_now;
  logic [AW-1:0] idx_now;

  logic          ready_q;
  logic          valid_q;
  logic          error_q;
  logic          out_load_q;

  logic          ram_re;
  logic [AW-1:0] ram_raddr;
  logic [31:0]   ram_rdata;

  logic [1:0]    unused_offset;

  always_comb begin
    offset       = dmem_addr_in - BASE_ADDR;
    in_range     = (dmem_addr_in >= BASE_ADDR) && ({2'b00, offset[31:2]} < DEPTH_WORDS);
    idx_now      = offset[AW+1:2];
    accept       = ready_q & (dmem_read_enable_in | dmem_write_enable_in);
    err_now      = ~in_range | (dmem_read_enable_in & dmem_write_enable_in);
    load_ok_now  = dmem_read_enable_in & ~err_now;
    store_ok_now = dmem_write_enable_in & ~err_now;
  end

  assign unused_offset = offset[1:0];

`ifdef RISCV_DMEM_WAIT_EN
  dmem_state_t   state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] idx_q;
  logic          load_ok_q;
  logic          err_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      load_ok_q  <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      out_load_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      unique case (state_q)
        IDLE, RESP: begin
          if (accept && (WAIT_CYCLES == 0)) begin
            state_q    <= RESP;
            ready_q    <= 1'b1;
            valid_q    <= 1'b1;
            error_q    <= err_now;
            out_load_q <= load_ok_now;
          end else if (accept) begin
            state_q   <= WAIT;
            ready_q   <= 1'b0;
            cnt_q     <= WAIT_CYCLES[3:0];
            idx_q     <= idx_now;
            load_ok_q <= load_ok_now;
            err_q     <= err_now;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q <= 4'd1) begin
            state_q    <= RESP;
            cnt_q      <= 4'd0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b1;
            error_q    <= err_q;
            out_load_q <= load_ok_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Loads read at the response edge; ready=0 during WAIT keeps stores out, so
  // this sees the same word as sampling at the accept edge.
  always_comb begin
    if (state_q == WAIT) begin
      ram_re    = (cnt_q <= 4'd1) & load_ok_q;
      ram_raddr = idx_q;
    end else begin
      ram_re    = accept & load_ok_now & (WAIT_CYCLES == 0);
      ram_raddr = idx_now;
    end
  end
`else
  logic [3:0] unused_wait;
  assign unused_wait = WAIT_CYCLES[3:0];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      out_load_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      valid_q <= accept;
      error_q <= accept & err_now;
      if (accept) begin
        out_load_q <= load_ok_now;
      end
    end
  end

  always_comb begin
    ram_re    = accept & load_ok_now;
    ram_raddr = idx_now;
  end
`endif

  dmem_bram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_bram (
    .clk_i  (clk_in),
    .we_i   (accept & store_ok_now),
    .waddr_i(idx_now),
    .wdata_i(dmem_data_in),
    .be_i   (dmem_byte_enable_in),
    .re_i   (ram_re),
    .raddr_i(ram_raddr),
    .rdata_o(ram_rdata)
  );

  // RAM output register only moves on load responses, so data holds between responses.
  assign dmem_data_out  = out_load_q ? ram_rdata : 32'h0;
  assign dmem_valid_out = valid_q;
  assign dmem_error_out = error_q;
  assign dmem_ready_out = ready_q;

endmodule

// File: tb/tb_riscv_dmem.sv
// Directed self-checking bench for riscv_dmem (both builds of RISCV_DMEM_WAIT_EN).
module tb_riscv_dmem;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef RISCV_DMEM_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        re;
  logic        we;
  logic [3:0]  be;
  logic [31:0] dmem_data_out;
  logic        dmem_valid_out;
  logic        dmem_ready_out;
  logic        dmem_error_out;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  riscv_dmem #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE),
    .WAIT_CYCLES(2)
  ) dut (
    .clk_in              (clk),
    .rst_in              (rst_n),
    .dmem_addr_in        (addr),
    .dmem_data_in        (wdata),
    .dmem_read_enable_in (re),
    .dmem_write_enable_in(we),
    .dmem_byte_enable_in (be),
    .dmem_data_out       (dmem_data_out),
    .dmem_valid_out      (dmem_valid_out),
    .dmem_ready_out      (dmem_ready_out),
    .dmem_error_out      (dmem_error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic r,
                       input logic w, input logic [3:0] b);
    addr  = a;
    wdata = d;
    re    = r;
    we    = w;
    be    = b;
  endtask

  task automatic clear_req();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request while ready, then waits (bounded) for its response.
  task automatic txn(input string tag, input logic [31:0] a, input logic [31:0] d,
                     input logic r, input logic w, input logic [3:0] b,
                     input logic [31:0] exp_data, input logic exp_err);
    int lat;
    drive(a, d, r, w, b);
    tick();
    clear_req();
    lat = 0;
    while (dmem_valid_out !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, " valid"}, {31'b0, dmem_valid_out}, 32'd1);
    check({tag, " latency"}, lat, W);
    check({tag, " data"}, dmem_data_out, exp_data);
    check({tag, " error"}, {31'b0, dmem_error_out}, {31'b0, exp_err});
  endtask

  initial begin
    rst_n = 1'b0;
    drive(BASE + 32'h40, 32'h1234_5678, 1'b0, 1'b1, 4'hF);
    repeat (3) tick();
    check("rst data", dmem_data_out, 32'h0);
    check("rst valid", {31'b0, dmem_valid_out}, 32'd0);
    check("rst error", {31'b0, dmem_error_out}, 32'd0);
    check("rst ready", {31'b0, dmem_ready_out}, 32'd0);
    clear_req();
    rst_n = 1'b1;
    #1;
    check("ready after release", {31'b0, dmem_ready_out}, 32'd0);
    tick();
    check("ready first cycle", {31'b0, dmem_ready_out}, 32'd1);

    txn("sw deadbeef", BASE + 32'h40, 32'hDEAD_BEEF, 1'b0, 1'b1, 4'hF, 32'h0, 1'b0);
    txn("lw deadbeef", BASE + 32'h40, 32'h0, 1'b1, 1'b0, 4'h0, 32'hDEAD_BEEF, 1'b0);
    tick();
    check("idle valid low", {31'b0, dmem_valid_out}, 32'd0);
    check("idle data hold", dmem_data_out, 32'hDEAD_BEEF);

    // Store then load on the very next accept: must see the new byte.
    txn("sb lane1", BASE + 32'h40, 32'h0000_7700, 1'b0, 1'b1, 4'b0010, 32'h0, 1'b0);
    txn("lw after sb", BASE + 32'h40, 32'h0, 1'b1, 1'b0, 4'h0, 32'hDEAD_77EF, 1'b0);
    txn("sw be0", BASE + 32'h40, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0);
    txn("lw after be0", BASE + 32'h40, 32'h0, 1'b1, 1'b0, 4'h0, 32'hDEAD_77EF, 1'b0);

    txn("lw past end", BASE + 4 * DEPTH, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b1);
    txn("lw below base", BASE - 32'h4, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b1);
    txn("sw past end", BASE + 4 * DEPTH, 32'h1111_1111, 1'b0, 1'b1, 4'hF, 32'h0, 1'b1);
    txn("rd+wr", BASE + 32'h40, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0, 1'b1);
    txn("lw after rd+wr", BASE + 32'h40, 32'h0, 1'b1, 1'b0, 4'h0, 32'hDEAD_77EF, 1'b0);
    txn("sw last", BASE + 4 * (DEPTH - 1), 32'h55AA_55AA, 1'b0, 1'b1, 4'hF, 32'h0, 1'b0);
    txn("lw last", BASE + 4 * (DEPTH - 1) + 32'h3, 32'h0, 1'b1, 1'b0, 4'h0, 32'h55AA_55AA,
        1'b0);
    txn("lw word0", BASE + 32'h40, 32'h0, 1'b1, 1'b0, 4'h0, 32'hDEAD_77EF, 1'b0);

`ifdef RISCV_DMEM_WAIT_EN
    // Ready throttling; a request presented while ready=0 must be ignored.
    tick();
    drive(BASE + 32'h48, 32'h0BAD_F00D, 1'b0, 1'b1, 4'hF);
    tick();
    check("ws ready N", {31'b0, dmem_ready_out}, 32'd0);
    check("ws valid N", {31'b0, dmem_valid_out}, 32'd0);
    drive(BASE + 32'h48, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'hF);
    tick();
    check("ws ready N+1", {31'b0, dmem_ready_out}, 32'd0);
    check("ws valid N+1", {31'b0, dmem_valid_out}, 32'd0);
    clear_req();
    tick();
    check("ws ready N+2", {31'b0, dmem_ready_out}, 32'd1);
    check("ws valid N+2", {31'b0, dmem_valid_out}, 32'd1);
    tick();
    check("ws valid after", {31'b0, dmem_valid_out}, 32'd0);
    txn("ws lw ignored", BASE + 32'h48, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0BAD_F00D, 1'b0);

    // Reset during WAIT: response dropped, committed store survives.
    drive(BASE + 32'h4C, 32'h1357_9BDF, 1'b0, 1'b1, 4'hF);
    tick();
    clear_req();
    rst_n = 1'b0;
    #1;
    check("midrst valid", {31'b0, dmem_valid_out}, 32'd0);
    check("midrst ready", {31'b0, dmem_ready_out}, 32'd0);
    repeat (3) tick();
    check("midrst no valid", {31'b0, dmem_valid_out}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("midrst valid post", {31'b0, dmem_valid_out}, 32'd0);
    txn("midrst lw", BASE + 32'h4C, 32'h0, 1'b1, 1'b0, 4'h0, 32'h1357_9BDF, 1'b0);
`endif

    // Store held active through reset must not reach the RAM.
    tick();
    rst_n = 1'b0;
    drive(BASE + 32'h40, 32'h1234_5678, 1'b0, 1'b1, 4'hF);
    repeat (3) tick();
    check("rst2 valid", {31'b0, dmem_valid_out}, 32'd0);
    clear_req();
    rst_n = 1'b1;
    tick();
    txn("lw after rst", BASE + 32'h40, 32'h0, 1'b1, 1'b0, 4'h0, 32'hDEAD_77EF, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
